// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_KILL = 3'd3,
    ST_OUT  = 3'd4,
    ST_HALT = 3'd5
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A word fetch target must have its two low address bits clear.
  function automatic logic low_bits_set(input logic [1:0] low);
    return (low != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus plus the valid/ready instruction link to decode.
interface pc_fetch_unit_if #(parameter int N = 32) ();

  logic         o_imem_req;
  logic [N-1:0] o_imem_addr;
  logic         i_imem_gnt;
  logic         i_imem_rvalid;
  logic [N-1:0] i_imem_rdata;
  logic         o_inst_valid;
  logic [N-1:0] o_inst;
  logic [N-1:0] o_inst_pc;
  logic         i_inst_ready;

  modport master (
    output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and single-outstanding fetch FSM with redirect kill.
// Optional misaligned-redirect trap into a HALT state: macro FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_redirect,
  input  logic [N-1:0]        i_redirect_pc,
  pc_fetch_unit_if.master     bus,
  output logic                o_fetch_misaligned
);

  fetch_state_t state_r, state_nx_s;
  logic [N-1:0] pc_r, pc_nx_s;
  logic [N-1:0] inst_r, inst_pc_r;
  logic         req_r, valid_r, mis_r, mis_nx_s;
  logic         capture_s, redir_bad_s;
  logic [N-1:0] tgt_s;

  assign tgt_s = i_redirect_pc & {{(N-2){1'b1}}, 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad_s = i_redirect & low_bits_set(i_redirect_pc[1:0]);
`else
  assign redir_bad_s = 1'b0;
`endif

  // Next-state, next-PC and capture decision.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    mis_nx_s   = mis_r;
    capture_s  = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nx_s = ST_REQ;
      end
      ST_REQ: begin
        if (redir_bad_s) begin
          mis_nx_s   = 1'b1;
          // A granted request still owes a response, so drain it first.
          state_nx_s = bus.i_imem_gnt ? ST_KILL : ST_HALT;
        end else if (bus.i_imem_gnt) begin
          if (i_redirect) begin
            state_nx_s = ST_KILL;
            pc_nx_s    = tgt_s;
          end else begin
            state_nx_s = ST_WAIT;
          end
        end else if (i_redirect) begin
          pc_nx_s = tgt_s;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redir_bad_s) begin
          mis_nx_s   = 1'b1;
          state_nx_s = bus.i_imem_rvalid ? ST_HALT : ST_KILL;
        end else if (bus.i_imem_rvalid) begin
          if (i_redirect) begin
            state_nx_s = ST_REQ;
            pc_nx_s    = tgt_s;
          end else begin
            state_nx_s = ST_OUT;
            capture_s  = 1'b1;
          end
        end else if (i_redirect) begin
          state_nx_s = ST_KILL;
          pc_nx_s    = tgt_s;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_KILL: begin
        if (redir_bad_s) begin
          mis_nx_s = 1'b1;
        end else if (i_redirect) begin
          pc_nx_s = tgt_s;
        end else begin
          pc_nx_s = pc_r;
        end
        if (bus.i_imem_rvalid) begin
          state_nx_s = (mis_r || redir_bad_s) ? ST_HALT : ST_REQ;
        end else begin
          state_nx_s = ST_KILL;
        end
      end
      ST_OUT: begin
        if (redir_bad_s) begin
          mis_nx_s   = 1'b1;
          state_nx_s = ST_HALT;
        end else if (i_redirect) begin
          state_nx_s = ST_REQ;
          pc_nx_s    = tgt_s;
        end else if (bus.i_inst_ready) begin
          state_nx_s = ST_REQ;
          pc_nx_s    = pc_r + N'(PC_INC);
        end else begin
          state_nx_s = ST_OUT;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_HALT: begin
        state_nx_s = ST_HALT;
      end
`endif
      default: begin
        state_nx_s = ST_BOOT;
      end
    endcase
  end

  // State, PC and registered outputs; req/valid are decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= ST_BOOT;
      pc_r      <= RESET_PC;
      req_r     <= 1'b0;
      valid_r   <= 1'b0;
      inst_r    <= N'(NOP_INST);
      inst_pc_r <= {N{1'b0}};
      mis_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      req_r   <= (state_nx_s == ST_REQ);
      valid_r <= (state_nx_s == ST_OUT);
      mis_r   <= mis_nx_s;
      if (capture_s) begin
        inst_r    <= bus.i_imem_rdata;
        inst_pc_r <= pc_r;
      end
    end
  end

  assign bus.o_imem_req   = req_r;
  assign bus.o_imem_addr  = pc_r;
  assign bus.o_inst_valid = valid_r;
  assign bus.o_inst       = inst_r;
  assign bus.o_inst_pc    = inst_pc_r;
  assign o_fetch_misaligned = mis_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory responder with programmable latency,
// accept/grant logs, and hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        gnt_en;
  logic        ready;
  logic        mis;
  int          lat;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic [31:0] gaddr[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];
  int          acc_cyc[$];

  pc_fetch_unit_if #(.N(32)) bus ();

  pc_fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_redirect         (redirect),
    .i_redirect_pc      (redirect_pc),
    .bus                (bus),
    .o_fetch_misaligned (mis)
  );

  always #5 clk = ~clk;

  assign bus.i_imem_gnt    = gnt_en;
  assign bus.i_inst_ready  = ready;
  assign bus.i_imem_rvalid = pend && (cnt == 1);
  assign bus.i_imem_rdata  = paddr + 32'h1000_0000;

  // Memory responder: one response lat cycles after each grant.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= 0;
      gaddr.delete();
      acc_pc.delete();
      acc_inst.delete();
      acc_cyc.delete();
    end else begin
      if (bus.o_imem_req && gnt_en) begin
        pend  <= 1'b1;
        cnt   <= lat;
        paddr <= bus.o_imem_addr;
        gaddr.push_back(bus.o_imem_addr);
      end else if (pend) begin
        if (cnt == 1) pend <= 1'b0;
        else cnt <= cnt - 1;
      end
      if (bus.o_inst_valid && ready && !redirect) begin
        acc_pc.push_back(bus.o_inst_pc);
        acc_inst.push_back(bus.o_inst);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; gnt_en = 1'b1; ready = 1'b1; lat = 1;
    repeat (3) tick();
    check_val("rst_req", {31'd0, bus.o_imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
    check_val("rst_inst", bus.o_inst, 32'h0000_0013);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !bus.o_inst_valid; i++) tick();
    check_val(tag, {31'd0, bus.o_inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 30 && !bus.o_imem_req; i++) tick();
    check_val(tag, {31'd0, bus.o_imem_req}, 32'd1);
  endtask

  task automatic redir(input logic [31:0] tgt);
    redirect = 1'b1; redirect_pc = tgt;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    logic any_valid;
    int   n;

    // Reset values and back-to-back stream 0x0, 0x4, 0x8.
    do_reset();
    check_val("rst_addr", bus.o_imem_addr, 32'h0);
    check_val("rst_inst_pc", bus.o_inst_pc, 32'h0);
    check_val("rst_mis", {31'd0, mis}, 32'd0);
    repeat (12) tick();
    check_val("t1_count", {31'd0, acc_pc.size() >= 3}, 32'd1);
    check_val("t1_pc0", acc_pc[0], 32'h0);
    check_val("t1_pc1", acc_pc[1], 32'h4);
    check_val("t1_pc2", acc_pc[2], 32'h8);
    check_val("t1_inst1", acc_inst[1], 32'h1000_0004);
    check_val("t1_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
    check_val("t1_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);

    // Decode stall in OUT: held instruction stable, no new fetch.
    do_reset();
    ready = 1'b0;
    wait_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t2_inst", bus.o_inst, 32'h1000_0000);
      check_val("t2_pc", bus.o_inst_pc, 32'h0);
      check_val("t2_req", {31'd0, bus.o_imem_req}, 32'd0);
    end
    check_val("t2_grants", gaddr.size(), 32'd1);
    ready = 1'b1;
    tick();
    check_val("t2_next_req", {31'd0, bus.o_imem_req}, 32'd1);
    check_val("t2_next_addr", bus.o_imem_addr, 32'h4);

    // Redirect in WAIT with a slow response: response dropped.
    do_reset();
    lat = 3;
    wait_req("t3_req");
    tick();
    redir(32'h0000_0100);
    check_val("t3_kill_req", {31'd0, bus.o_imem_req}, 32'd0);
    check_val("t3_kill_addr", bus.o_imem_addr, 32'h100);
    any_valid = 1'b0;
    for (int i = 0; i < 30 && !bus.o_imem_req; i++) begin
      any_valid = any_valid | bus.o_inst_valid;
      tick();
    end
    check_val("t3_no_valid", {31'd0, any_valid}, 32'd0);
    check_val("t3_req_addr", bus.o_imem_addr, 32'h100);
    wait_valid("t3_valid");
    check_val("t3_inst_pc", bus.o_inst_pc, 32'h100);
    check_val("t3_inst", bus.o_inst, 32'h1000_0100);

    // Redirect coincident with grant: old response killed.
    do_reset();
    wait_req("t4_req");
    redir(32'h0000_0200);
    check_val("t4_kill_req", {31'd0, bus.o_imem_req}, 32'd0);
    wait_valid("t4_valid");
    check_val("t4_inst_pc", bus.o_inst_pc, 32'h200);
    tick();
    check_val("t4_acc_n", acc_pc.size(), 32'd1);
    check_val("t4_acc_pc", acc_pc[0], 32'h200);
    check_val("t4_grant1", gaddr[1], 32'h200);

    // Redirect in OUT beats ready; then PC wrap at the top of memory.
    do_reset();
    wait_valid("t5_valid");
    redir(32'h0000_0300);
    check_val("t5_noacc", acc_pc.size(), 32'd0);
    check_val("t5_addr", bus.o_imem_addr, 32'h300);
    check_val("t5_valid_drop", {31'd0, bus.o_inst_valid}, 32'd0);
    wait_valid("t5_valid2");
    check_val("t5_inst_pc", bus.o_inst_pc, 32'h300);
    redir(32'hFFFF_FFFC);
    wait_valid("t5_valid3");
    check_val("t5_top_pc", bus.o_inst_pc, 32'hFFFF_FFFC);
    tick();
    check_val("t5_wrap_req", {31'd0, bus.o_imem_req}, 32'd1);
    check_val("t5_wrap_addr", bus.o_imem_addr, 32'h0);

    // Misaligned redirect while an ungranted request is pending.
    do_reset();
    gnt_en = 1'b0;
    wait_req("t6_req");
    redir(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("t6_mis", {31'd0, mis}, 32'd1);
    n = 0;
    gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = n + {31'd0, bus.o_imem_req} + {31'd0, bus.o_inst_valid};
      tick();
    end
    check_val("t6_halt_quiet", n, 32'd0);
    check_val("t6_mis_sticky", {31'd0, mis}, 32'd1);
`else
    check_val("t6_req_held", {31'd0, bus.o_imem_req}, 32'd1);
    check_val("t6_addr", bus.o_imem_addr, 32'h100);
    check_val("t6_mis", {31'd0, mis}, 32'd0);
    gnt_en = 1'b1;
    wait_valid("t6_valid");
    check_val("t6_inst_pc", bus.o_inst_pc, 32'h100);
    n = gaddr.size();
    check_val("t6_grants", n, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
